uart_tx_arbiter: RTL and testbench

//  Round-robin arbiter sharing one UART transmitter between NUM_REQ byte-stream clients.
//  - Grants the transmitter to one client for a whole packet (bytes up to and including the one marked last).
//  - Hands each accepted byte to the transmitter with a one-cycle tx_start.
//  - Revokes a grant if the client stalls mid-packet.
//  - Sits between protocol/message engines and the board UART TX, the transmit-side counterpart of the UART receiver.

---
 rtl/uart_tx_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lends one shared UART transmitter to NUM_REQ byte-stream
// clients for whole packets, revoking the grant when the owner stalls too long.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int TIMEOUT_CLKS = 2400
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic [NUM_REQ-1:0]     grant,
    output logic [2:0]             grant_id,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    input  logic                   tx_busy,
    output logic                   timeout_err
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT_CLKS);
    localparam logic [TW-1:0]      TMAX     = TW'(TIMEOUT_CLKS - 1);
    localparam logic [IW-1:0]      PTR_INIT = IW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);

    typedef enum logic [2:0] {IDLE, GRANT, START, BLANK, WAIT} state_t;

    state_t              state, state_n;
    logic [IW-1:0]       ptr, ptr_n;
    logic [IW-1:0]       owner, owner_n;
    logic [TW-1:0]       timer, timer_n;
    logic                last_f, last_n;
    logic [7:0]          data_n;
    logic                start_n;
    logic [NUM_REQ-1:0]  ack_n;
    logic [NUM_REQ-1:0]  grant_n;
    logic [2:0]          gid_n;
    logic                terr_n;
    logic                release_g;

    logic [7:0]          client_byte [NUM_REQ];
    logic                pick_hi_ok, pick_lo_ok, pick_ok;
    logic [IW-1:0]       pick_hi, pick_lo, pick;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            client_byte[i] = req_data[8*i +: 8];
        end
    end

    // Lowest requester above the pointer wins; otherwise wrap to the lowest one at or below it.
    always_comb begin
        pick_hi_ok = 1'b0;
        pick_lo_ok = 1'b0;
        pick_hi    = '0;
        pick_lo    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (i > int'(ptr)) begin
                    pick_hi_ok = 1'b1;
                    pick_hi    = IW'(i);
                end else begin
                    pick_lo_ok = 1'b1;
                    pick_lo    = IW'(i);
                end
            end
        end
    end

    assign pick_ok = pick_hi_ok | pick_lo_ok;
    assign pick    = pick_hi_ok ? pick_hi : pick_lo;

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        owner_n   = owner;
        timer_n   = timer;
        last_n    = last_f;
        data_n    = tx_data;
        grant_n   = grant;
        gid_n     = grant_id;
        start_n   = 1'b0;
        ack_n     = '0;
        terr_n    = 1'b0;
        release_g = 1'b0;
        case (state)
            IDLE: begin
                if (pick_ok) begin
                    state_n = GRANT;
                    owner_n = pick;
                    grant_n = ONE << pick;
                    gid_n   = 3'(pick);
                    timer_n = '0;
                end
            end
            GRANT: begin
                if (req_valid[owner] && !tx_busy) begin
                    state_n = START;
                    data_n  = client_byte[owner];
                    last_n  = req_last[owner];
                    start_n = 1'b1;
                    ack_n   = ONE << owner;
                end else if (!req_valid[owner] && !req[owner]) begin
                    release_g = 1'b1;
                end else if (!req_valid[owner] && timer == TMAX) begin
                    release_g = 1'b1;
                    terr_n    = 1'b1;
                end else if (timer != TMAX) begin
                    timer_n = timer + TW'(1);
                end
            end
            START: state_n = BLANK;
            // The transmitter may take a cycle to raise busy, so it is not looked at here.
            BLANK: state_n = WAIT;
            WAIT: begin
                if (!tx_busy) begin
                    if (last_f) begin
                        release_g = 1'b1;
                    end else begin
                        state_n = GRANT;
                        timer_n = '0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (release_g) begin
            state_n = IDLE;
            grant_n = '0;
            gid_n   = '0;
            ptr_n   = owner;
            timer_n = '0;
        end

        if (!enable) begin
            state_n = IDLE;
            ptr_n   = PTR_INIT;
            owner_n = '0;
            timer_n = '0;
            last_n  = 1'b0;
            data_n  = '0;
            grant_n = '0;
            gid_n   = '0;
            start_n = 1'b0;
            ack_n   = '0;
            terr_n  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= PTR_INIT;
            owner       <= '0;
            timer       <= '0;
            last_f      <= 1'b0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            req_ack     <= '0;
            grant       <= '0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            owner       <= owner_n;
            timer       <= timer_n;
            last_f      <= last_n;
            tx_data     <= data_n;
            tx_start    <= start_n;
            req_ack     <= ack_n;
            grant       <= grant_n;
            grant_id    <= gid_n;
            timeout_err <= terr_n;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: scripted clients, a simple transmitter model and a
// packet-level reference model compared against the arbiter on every cycle.
module tb_uart_tx_arbiter;
    localparam int N   = 4;
    localparam int TMO = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ack;
    logic [N-1:0]   grant;
    logic [2:0]     grant_id;
    logic [7:0]     tx_data;
    logic           tx_start;
    logic           tx_busy;
    logic           timeout_err;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CLKS(TMO)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .req(req), .req_data(req_data), .req_valid(req_valid), .req_last(req_last),
        .req_ack(req_ack), .grant(grant), .grant_id(grant_id),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Client scripts: {last, byte} per entry, consumed on each observed ack.
    logic [8:0] script [N][16];
    int         rd_ptr [N];
    int         wr_cnt [N];
    logic       stall [N];
    logic       stall_req [N];

    // Transmitter model: busy for busy_len cycles starting tx_lat cycles after tx_start.
    int cyc = 0;
    int tx_lat = 0;
    int busy_len = 10;
    int busy_from = 0;
    int busy_to = 0;

    // Reference model: who owns the transmitter and what phase the current byte is in.
    int         m_owner;
    int         m_rr;
    int         m_hold;
    int         m_since;
    logic       m_last;
    logic [N-1:0] n_grant, e_grant, n_ack, e_ack;
    logic [2:0]   n_gid, e_gid;
    logic         n_start, e_start, n_terr, e_terr;
    logic [7:0]   n_data, e_data;

    // Event logs observed on the DUT, used for the literal expectations.
    logic [2:0] glog [64];
    logic [7:0] blog [64];
    int glen = 0;
    int blen = 0;
    int ack_cnt [N];
    int terr_cnt = 0;
    int ncyc = 0;
    int g_rise = 0;
    int last_dur = 0;
    logic [N-1:0] prev_grant = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void modelReset();
        m_owner = -1;
        m_rr    = N - 1;
        m_hold  = 0;
        m_since = 0;
        m_last  = 1'b0;
        n_grant = '0;
        n_gid   = '0;
        n_ack   = '0;
        n_start = 1'b0;
        n_terr  = 1'b0;
        n_data  = '0;
    endfunction

    function automatic void copyExpect();
        e_grant = n_grant;
        e_gid   = n_gid;
        e_ack   = n_ack;
        e_start = n_start;
        e_terr  = n_terr;
        e_data  = n_data;
    endfunction

    // Predicts the outputs after the coming edge from the inputs the DUT will sample there.
    function automatic void modelStep();
        int o;
        int c;
        n_start = 1'b0;
        n_ack   = '0;
        n_terr  = 1'b0;
        if (rst || !enable) begin
            modelReset();
            return;
        end
        o = m_owner;
        if (o < 0) begin
            for (int d = N; d >= 1; d--) begin
                c = (m_rr + d) % N;
                if (req[c]) m_owner = c;
            end
            m_hold  = 0;
            m_since = 0;
        end else if (m_since == 0) begin
            if (req_valid[o] && !tx_busy) begin
                n_start  = 1'b1;
                n_ack[o] = 1'b1;
                n_data   = req_data[8*o +: 8];
                m_last   = req_last[o];
                m_since  = 1;
            end else if (!req_valid[o] && !req[o]) begin
                m_rr = o;
                m_owner = -1;
            end else if (!req_valid[o] && m_hold == TMO - 1) begin
                m_rr = o;
                m_owner = -1;
                n_terr = 1'b1;
            end else begin
                m_hold++;
            end
        end else if (m_since < 3) begin
            m_since++;
        end else if (!tx_busy) begin
            if (m_last) begin
                m_rr = o;
                m_owner = -1;
            end else begin
                m_since = 0;
                m_hold  = 0;
            end
        end
        n_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        n_gid   = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
    endfunction

    function automatic void popAcks();
        for (int i = 0; i < N; i++) begin
            if (req_ack[i] && !stall[i] && rd_ptr[i] < wr_cnt[i]) rd_ptr[i]++;
        end
    endfunction

    function automatic void driveClients();
        for (int i = 0; i < N; i++) begin
            if (stall[i]) begin
                req[i] = stall_req[i];
                req_valid[i] = 1'b0;
                req_last[i] = 1'b0;
            end else if (rd_ptr[i] < wr_cnt[i]) begin
                req[i] = 1'b1;
                req_valid[i] = 1'b1;
                req_data[8*i +: 8] = script[i][rd_ptr[i]][7:0];
                req_last[i] = script[i][rd_ptr[i]][8];
            end else begin
                req[i] = 1'b0;
                req_valid[i] = 1'b0;
                req_last[i] = 1'b0;
            end
        end
    endfunction

    function automatic void queueByte(input int c, input logic [7:0] b, input logic last);
        script[c][wr_cnt[c]] = {last, b};
        wr_cnt[c]++;
    endfunction

    function automatic bit quiet();
        bit q = (m_owner < 0) && !tx_busy;
        for (int i = 0; i < N; i++) begin
            if (!stall[i] && rd_ptr[i] < wr_cnt[i]) q = 0;
            if (stall[i] && stall_req[i]) q = 0;
        end
        return q;
    endfunction

    task automatic applyStimulus(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            modelStep();
            @(posedge clk);
            copyExpect();
            #1;
            cyc++;
            if (tx_start) begin
                busy_from = cyc + tx_lat;
                busy_to   = busy_from + busy_len;
            end
            tx_busy = (cyc >= busy_from) && (cyc < busy_to);
            popAcks();
            driveClients();
        end
    endtask

    task automatic runUntilQuiet(input string name, input int budget);
        int n = 0;
        do begin
            applyStimulus(1);
            n++;
        end while (!quiet() && n < budget);
        checkOutput(name, 32'(quiet()), 32'd1);
    endtask

    task automatic pulseReset();
        #2 rst = 1'b1;
        #1;
        modelReset();
        copyExpect();
        checkOutput("rst_grant", 32'(grant), 32'd0);
        checkOutput("rst_grant_id", 32'(grant_id), 32'd0);
        checkOutput("rst_tx_start", 32'(tx_start), 32'd0);
        checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
        checkOutput("rst_req_ack", 32'(req_ack), 32'd0);
        applyStimulus(1);
        rst = 1'b0;
    endtask

    // Per-cycle comparison against the model plus event logging.
    initial begin
        forever begin
            @(negedge clk);
            ncyc++;
            checkOutput("grant", 32'(grant), 32'(e_grant));
            checkOutput("grant_id", 32'(grant_id), 32'(e_gid));
            checkOutput("tx_start", 32'(tx_start), 32'(e_start));
            checkOutput("req_ack", 32'(req_ack), 32'(e_ack));
            checkOutput("timeout_err", 32'(timeout_err), 32'(e_terr));
            checkOutput("tx_data", 32'(tx_data), 32'(e_data));
            if (grant != '0 && prev_grant == '0) begin
                if (glen < 64) glog[glen] = grant_id;
                glen++;
                g_rise = ncyc;
            end
            if (grant == '0 && prev_grant != '0) last_dur = ncyc - g_rise;
            if (tx_start) begin
                if (blen < 64) blog[blen] = tx_data;
                blen++;
            end
            for (int i = 0; i < N; i++) if (req_ack[i]) ack_cnt[i]++;
            if (timeout_err) terr_cnt++;
            prev_grant = grant;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n, g0, b0, a0, t0;
        rst = 1'b1;
        enable = 1'b1;
        req = '0;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        tx_busy = 1'b0;
        for (int i = 0; i < N; i++) begin
            rd_ptr[i] = 0;
            wr_cnt[i] = 0;
            stall[i] = 1'b0;
            stall_req[i] = 1'b0;
            ack_cnt[i] = 0;
        end
        modelReset();
        copyExpect();
        @(posedge clk);
        #1;
        checkOutput("reset_grant", 32'(grant), 32'd0);
        checkOutput("reset_tx_start", 32'(tx_start), 32'd0);
        checkOutput("reset_timeout_err", 32'(timeout_err), 32'd0);
        rst = 1'b0;

        // Single client, three-byte packet.
        $display("[TB] single client packet");
        g0 = glen; b0 = blen; a0 = ack_cnt[0];
        queueByte(0, 8'h55, 1'b0);
        queueByte(0, 8'hA3, 1'b0);
        queueByte(0, 8'h0F, 1'b1);
        driveClients();
        runUntilQuiet("t1_done", 300);
        checkOutput("t1_bytes", 32'(blen - b0), 32'd3);
        checkOutput("t1_byte0", 32'(blog[b0]), 32'h55);
        checkOutput("t1_byte1", 32'(blog[b0+1]), 32'hA3);
        checkOutput("t1_byte2", 32'(blog[b0+2]), 32'h0F);
        checkOutput("t1_acks", 32'(ack_cnt[0] - a0), 32'd3);
        checkOutput("t1_owner", 32'(glog[g0]), 32'd0);

        // Clear the pointer so client 0 is first, then all four contend.
        $display("[TB] contention");
        enable = 1'b0;
        applyStimulus(1);
        enable = 1'b1;
        busy_len = 4;
        g0 = glen; b0 = blen;
        for (int i = 0; i < N; i++) queueByte(i, 8'(8'h10 + i), 1'b1);
        queueByte(0, 8'h20, 1'b1);
        driveClients();
        runUntilQuiet("t2_done", 300);
        checkOutput("t2_grants", 32'(glen - g0), 32'd5);
        checkOutput("t2_order0", 32'(glog[g0]), 32'd0);
        checkOutput("t2_order1", 32'(glog[g0+1]), 32'd1);
        checkOutput("t2_order2", 32'(glog[g0+2]), 32'd2);
        checkOutput("t2_order3", 32'(glog[g0+3]), 32'd3);
        checkOutput("t2_order4", 32'(glog[g0+4]), 32'd0);
        checkOutput("t2_last_byte", 32'(blog[b0+4]), 32'h20);

        // Client 1 stalls with no byte; client 2 waits behind it.
        $display("[TB] timeout");
        g0 = glen; t0 = terr_cnt;
        stall[1] = 1'b1;
        stall_req[1] = 1'b1;
        queueByte(2, 8'h33, 1'b1);
        driveClients();
        n = 0;
        while (!timeout_err && n < 60) begin
            applyStimulus(1);
            n++;
        end
        checkOutput("t3_timeout_seen", 32'(timeout_err), 32'd1);
        stall_req[1] = 1'b0;
        driveClients();
        applyStimulus(1);
        checkOutput("t3_grant_len", 32'(last_dur), 32'(TMO));
        runUntilQuiet("t3_done", 200);
        stall[1] = 1'b0;
        checkOutput("t3_terr_count", 32'(terr_cnt - t0), 32'd1);
        checkOutput("t3_first", 32'(glog[g0]), 32'd1);
        checkOutput("t3_next", 32'(glog[g0+1]), 32'd2);

        // Transmitter raises busy a cycle late.
        $display("[TB] slow busy");
        tx_lat = 1;
        busy_len = 6;
        b0 = blen;
        queueByte(3, 8'hC3, 1'b0);
        queueByte(3, 8'h3C, 1'b1);
        driveClients();
        runUntilQuiet("t4_done", 200);
        checkOutput("t4_bytes", 32'(blen - b0), 32'd2);
        checkOutput("t4_byte1", 32'(blog[b0+1]), 32'h3C);

        // Client 2 abandons its grant without offering a byte.
        $display("[TB] abort and reset");
        tx_lat = 0;
        busy_len = 10;
        a0 = ack_cnt[2]; t0 = terr_cnt;
        stall[2] = 1'b1;
        stall_req[2] = 1'b1;
        driveClients();
        n = 0;
        while (!grant[2] && n < 20) begin
            applyStimulus(1);
            n++;
        end
        checkOutput("t5_granted", 32'(grant[2]), 32'd1);
        stall_req[2] = 1'b0;
        driveClients();
        runUntilQuiet("t5a_done", 100);
        stall[2] = 1'b0;
        checkOutput("t5_no_ack", 32'(ack_cnt[2] - a0), 32'd0);
        checkOutput("t5_no_timeout", 32'(terr_cnt - t0), 32'd0);

        queueByte(2, 8'h71, 1'b0);
        queueByte(2, 8'h72, 1'b0);
        queueByte(2, 8'h73, 1'b1);
        driveClients();
        n = 0;
        while (!tx_start && n < 30) begin
            applyStimulus(1);
            n++;
        end
        checkOutput("t5_started", 32'(tx_start), 32'd1);
        applyStimulus(3);
        queueByte(3, 8'h3A, 1'b1);
        queueByte(0, 8'h0A, 1'b1);
        driveClients();
        pulseReset();
        g0 = glen;
        runUntilQuiet("t5b_done", 400);
        checkOutput("t5_after_rst0", 32'(glog[g0]), 32'd0);
        checkOutput("t5_after_rst1", 32'(glog[g0+1]), 32'd2);
        checkOutput("t5_after_rst2", 32'(glog[g0+2]), 32'd3);

        // Synchronous clear while waiting on the transmitter.
        $display("[TB] enable clear");
        b0 = blen;
        queueByte(1, 8'h61, 1'b0);
        queueByte(1, 8'h62, 1'b1);
        driveClients();
        n = 0;
        while (!tx_start && n < 30) begin
            applyStimulus(1);
            n++;
        end
        checkOutput("t6_started", 32'(tx_start), 32'd1);
        applyStimulus(3);
        enable = 1'b0;
        applyStimulus(1);
        enable = 1'b1;
        checkOutput("t6_clr_grant", 32'(grant), 32'd0);
        checkOutput("t6_clr_tx_data", 32'(tx_data), 32'd0);
        runUntilQuiet("t6_done", 300);
        checkOutput("t6_bytes", 32'(blen - b0), 32'd2);
        checkOutput("t6_byte1", 32'(blog[b0+1]), 32'h62);

        applyStimulus(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
